// File: rtl/dog_window_5x5.sv
// Serpentine 5x5 window assembler between the 5-port DoG RAM read stage and keypoint detection.
// Optional center/peak outputs are built in when DOG_WIN_PEAK_EN is defined.
module dog_window_5x5 #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_dir,
  input  logic             in_rowstep,
  input  logic [CW-1:0]    in_x,
  input  logic [CW-1:0]    in_y,
  input  logic [PW-1:0]    d1,
  input  logic [PW-1:0]    d2,
  input  logic [PW-1:0]    d3,
  input  logic [PW-1:0]    d4,
  input  logic [PW-1:0]    d5,
  output logic [25*PW-1:0] win,
  output logic             win_valid,
  output logic [CW-1:0]    out_x,
  output logic [CW-1:0]    out_y
`ifdef DOG_WIN_PEAK_EN
  ,
  output logic [PW-1:0]    win_center,
  output logic             win_peak
`endif
);

  typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [2:0]        fill_cnt_q, fill_cnt_d;
  logic [25*PW-1:0]  win_q, win_d;
  logic              win_valid_q, win_valid_d;
  logic [CW-1:0]     out_x_q, out_x_d;
  logic [CW-1:0]     out_y_q, out_y_d;
  logic [PW-1:0]     d_s [5];
  logic              restart_s;

  always_comb begin
    d_s[0] = d1;
    d_s[1] = d2;
    d_s[2] = d3;
    d_s[3] = d4;
    d_s[4] = d5;
  end

  // A column load at the frame origin restarts filling regardless of state.
  assign restart_s = in_valid && !in_rowstep && (in_x == {CW{1'b0}}) && (in_y == {CW{1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      fill_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (restart_s) begin
      state_d    = FILL;
      fill_cnt_d = 3'd1;
    end else if (in_valid && !in_rowstep) begin
      case (state_q)
        FILL: begin
          fill_cnt_d = fill_cnt_q + 3'd1;
          if (fill_cnt_q == 3'd4) begin
            state_d = RUN;
          end else begin
            state_d = FILL;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = FILL;
      endcase
    end else begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
    end
  end

  always_comb begin
    win_valid_d = 1'b0;
    if (!in_valid || restart_s) begin
      win_valid_d = 1'b0;
    end else begin
      case (state_q)
        FILL:    win_valid_d = !in_rowstep && (fill_cnt_q == 3'd4);
        RUN:     win_valid_d = 1'b1;
        default: win_valid_d = 1'b0;
      endcase
    end
  end

  // Shift the window toward the scan direction and insert the new column or bottom row.
  always_comb begin
    win_d   = win_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    if (in_valid) begin
      out_x_d = in_x;
      out_y_d = in_y;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          if (in_rowstep) begin
            win_d[(r*5+c)*PW +: PW] = (r == 4) ? d_s[c] : win_q[((r+1)*5+c)*PW +: PW];
          end else if (!in_dir) begin
            win_d[(r*5+c)*PW +: PW] = (c == 4) ? d_s[r] : win_q[(r*5+c+1)*PW +: PW];
          end else begin
            win_d[(r*5+c)*PW +: PW] = (c == 0) ? d_s[r] : win_q[(r*5+c-1)*PW +: PW];
          end
        end
      end
    end else begin
      win_d = win_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q       <= {(25*PW){1'b0}};
      win_valid_q <= 1'b0;
      out_x_q     <= {CW{1'b0}};
      out_y_q     <= {CW{1'b0}};
    end else begin
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign win       = win_q;
  assign win_valid = win_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

`ifdef DOG_WIN_PEAK_EN
  logic [PW-1:0] center_q, center_d;
  logic          peak_q, peak_d;

  // Center must strictly exceed all 24 neighbours of the window being registered.
  always_comb begin
    center_d = win_d[12*PW +: PW];
    peak_d   = win_valid_d;
    for (int i = 0; i < 25; i++) begin
      if (i != 12 && win_d[i*PW +: PW] >= center_d) begin
        peak_d = 1'b0;
      end else begin
        peak_d = peak_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      center_q <= {PW{1'b0}};
      peak_q   <= 1'b0;
    end else begin
      center_q <= center_d;
      peak_q   <= peak_d;
    end
  end

  assign win_center = center_q;
  assign win_peak   = peak_q;
`endif

endmodule

// File: tb/tb_dog_window_5x5.sv
// Directed self-checking bench for dog_window_5x5 (peak checks only when DOG_WIN_PEAK_EN is defined).
module tb_dog_window_5x5;
  localparam int PW = 8;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_dir = 1'b0, in_rowstep = 1'b0;
  logic [CW-1:0]    in_x = '0, in_y = '0;
  logic [PW-1:0]    d1 = '0, d2 = '0, d3 = '0, d4 = '0, d5 = '0;
  logic [25*PW-1:0] win;
  logic             win_valid;
  logic [CW-1:0]    out_x, out_y;
`ifdef DOG_WIN_PEAK_EN
  logic [PW-1:0]    win_center;
  logic             win_peak;
`endif

  int checks = 0;
  int errors = 0;

  dog_window_5x5 #(.PW(PW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_dir(in_dir), .in_rowstep(in_rowstep),
    .in_x(in_x), .in_y(in_y), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .win(win), .win_valid(win_valid), .out_x(out_x), .out_y(out_y)
`ifdef DOG_WIN_PEAK_EN
    , .win_center(win_center), .win_peak(win_peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int r, input int c);
    return {24'd0, win[(r*5+c)*PW +: PW]};
  endfunction

  // One load: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic load(input logic rs, input logic dir, input logic [CW-1:0] x, input logic [CW-1:0] y,
                      input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [PW-1:0] c,
                      input logic [PW-1:0] d, input logic [PW-1:0] e);
    @(negedge clk);
    in_valid = 1'b1; in_rowstep = rs; in_dir = dir; in_x = x; in_y = y;
    d1 = a; d2 = b; d3 = c; d4 = d; d5 = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_win", {31'd0, |win}, 32'd0);
    check("rst_valid", {31'd0, win_valid}, 32'd0);
    check("rst_x", {24'd0, out_x}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill: (r,c) = 10c+r+1
    for (int k = 0; k < 5; k++) begin
      load(1'b0, 1'b0, 8'(k + 1), 8'd3, 8'(10*k+1), 8'(10*k+2), 8'(10*k+3), 8'(10*k+4), 8'(10*k+5));
      check($sformatf("fill_valid_%0d", k), {31'd0, win_valid}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("fill_00", pix(0, 0), 32'd1);
    check("fill_44", pix(4, 4), 32'd45);
    check("fill_23", pix(2, 3), 32'd33);
    check("fill_x", {24'd0, out_x}, 32'd5);
    check("fill_y", {24'd0, out_y}, 32'd3);

    // Idle cycle holds the window and drops valid
    @(posedge clk);
    #1;
    check("hold_valid", {31'd0, win_valid}, 32'd0);
    check("hold_00", pix(0, 0), 32'd1);
    check("hold_x", {24'd0, out_x}, 32'd5);

    // Direction reversal
    load(1'b0, 1'b1, 8'd4, 8'd3, 8'd90, 8'd91, 8'd92, 8'd93, 8'd94);
    check("dir_valid", {31'd0, win_valid}, 32'd1);
    check("dir_00", pix(0, 0), 32'd90);
    check("dir_40", pix(4, 0), 32'd94);
    check("dir_01", pix(0, 1), 32'd1);
    check("dir_44", pix(4, 4), 32'd35);
    check("dir_x", {24'd0, out_x}, 32'd4);

    // Row step
    load(1'b1, 1'b0, 8'd4, 8'd4, 8'd200, 8'd201, 8'd202, 8'd203, 8'd204);
    check("row_valid", {31'd0, win_valid}, 32'd1);
    check("row_40", pix(4, 0), 32'd200);
    check("row_44", pix(4, 4), 32'd204);
    check("row_00", pix(0, 0), 32'd91);
    check("row_01", pix(0, 1), 32'd2);
    check("row_34", pix(3, 4), 32'd35);
    check("row_y", {24'd0, out_y}, 32'd4);

    // Frame restart mid-RUN, with a non-counting row load inside FILL
    load(1'b0, 1'b0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    check("rs_valid_1", {31'd0, win_valid}, 32'd0);
    check("rs_col_40", pix(4, 4), 32'd1);
    load(1'b0, 1'b0, 8'd1, 8'd0, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2);
    check("rs_valid_2", {31'd0, win_valid}, 32'd0);
    load(1'b1, 1'b0, 8'd1, 8'd1, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7);
    check("rs_valid_row", {31'd0, win_valid}, 32'd0);
    load(1'b0, 1'b0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3);
    check("rs_valid_3", {31'd0, win_valid}, 32'd0);
    load(1'b0, 1'b0, 8'd3, 8'd1, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4);
    check("rs_valid_4", {31'd0, win_valid}, 32'd0);
    load(1'b0, 1'b0, 8'd4, 8'd1, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    check("rs_valid_5", {31'd0, win_valid}, 32'd1);
    check("rs_44", pix(4, 4), 32'd5);

    // Reset wins over a simultaneous load
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_rowstep = 1'b0; in_dir = 1'b0; in_x = 8'd9; in_y = 8'd9;
    d1 = 8'd55; d2 = 8'd55; d3 = 8'd55; d4 = 8'd55; d5 = 8'd55;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rstp_win", {31'd0, |win}, 32'd0);
    check("rstp_valid", {31'd0, win_valid}, 32'd0);
    check("rstp_x", {24'd0, out_x}, 32'd0);
    check("rstp_y", {24'd0, out_y}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      load(1'b0, 1'b0, 8'(k + 1), 8'd2, 8'd5, 8'd5, 8'(k == 2 ? 9 : 5), 8'd5, 8'd5);
      check($sformatf("refill_valid_%0d", k), {31'd0, win_valid}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("refill_22", pix(2, 2), 32'd9);

`ifdef DOG_WIN_PEAK_EN
    check("peak_hi", {31'd0, win_peak}, 32'd1);
    check("peak_center", {24'd0, win_center}, 32'd9);
    for (int k = 0; k < 5; k++) begin
      load(1'b0, 1'b0, 8'(k + 1), 8'd3, 8'd5, 8'd5, 8'((k == 1 || k == 2) ? 9 : 5), 8'd5, 8'd5);
    end
    check("tie_valid", {31'd0, win_valid}, 32'd1);
    check("tie_center", {24'd0, win_center}, 32'd9);
    check("tie_peak", {31'd0, win_peak}, 32'd0);
    @(posedge clk);
    #1;
    check("idle_peak", {31'd0, win_peak}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
